ray_frame_scheduler: RTL

// Frame-level sequencer for the raycasting pipeline. Each frame it snapshots the controller pose,

---
 rtl/raycast_pkg.sv | 26 ++
 rtl/ray_frame_scheduler_if.sv | 26 ++
 rtl/ray_frame_scheduler_issue_counter.sv | 27 ++
 rtl/ray_frame_scheduler.sv | 113 +++++++++++
 4 files changed

// File: rtl/raycast_pkg.sv
// Shared raycasting types: scheduler states, pose payload and screen geometry.
package raycast_pkg;

    localparam int unsigned SCREEN_WIDTH  = 320;
    localparam int unsigned SCREEN_HEIGHT = 240;
    localparam int unsigned POSE_W        = 96;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LATCH   = 3'd1,
        ISSUE   = 3'd2,
        DRAIN   = 3'd3,
        WAIT_VS = 3'd4,
        SWAP    = 3'd5
    } sched_state_t;

    typedef struct packed {
        logic [15:0] pos_x;
        logic [15:0] pos_y;
        logic [15:0] dir_x;
        logic [15:0] dir_y;
        logic [15:0] plane_x;
        logic [15:0] plane_y;
    } pose_t;

endpackage

// File: rtl/ray_frame_scheduler_if.sv
// Ray request channel from the frame scheduler into ray_calculations / DDA-in FIFO.
interface ray_frame_scheduler_if #(
    parameter int unsigned HW = 9
);
    import raycast_pkg::*;

    logic          ray_valid_out;
    logic          ray_ready_in;
    logic [HW-1:0] hcount_out;
    pose_t         pose_out;

    modport master (
        output ray_valid_out,
        output hcount_out,
        output pose_out,
        input  ray_ready_in
    );

    modport slave (
        input  ray_valid_out,
        input  hcount_out,
        input  pose_out,
        output ray_ready_in
    );

endinterface

// File: rtl/ray_frame_scheduler_issue_counter.sv
// Column counter for ray requests: advances on each accepted transfer, flags the last column.
module ray_issue_counter #(
    parameter int unsigned SCREEN_WIDTH = 320,
    parameter int unsigned HW           = 9
) (
    input  logic          pixel_clk_in,
    input  logic          rst_n_in,
    input  logic          clear,
    input  logic          advance,
    output logic [HW-1:0] hcount,
    output logic          last_c
);

    assign last_c = (hcount == HW'(SCREEN_WIDTH - 1));

    // Holds on the last column; the next frame's LATCH clears it.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hcount <= '0;
        end else if (clear) begin
            hcount <= '0;
        end else if (advance && !last_c) begin
            hcount <= hcount + HW'(1);
        end
    end

endmodule

// File: rtl/ray_frame_scheduler.sv
// Frame sequencer: snapshots the pose, issues one ray per column, drains, then swaps buffers on vsync.
module ray_frame_scheduler
    import raycast_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = 320,
    parameter int unsigned HW            = 9,
    parameter int unsigned DRAIN_TIMEOUT = 2000000
) (
    input  logic                         pixel_clk_in,
    input  logic                         rst_n_in,
    input  logic                         enable_in,
    input  pose_t                        pose_in,
    ray_frame_scheduler_if.master        ray_if,
    input  logic                         ray_last_pixel_in,
    input  logic                         video_last_pixel_in,
    output logic                         swap_out,
    output logic [7:0]                   frame_count_out,
    output logic                         overrun_out,
    output logic [2:0]                   state_out
);

    localparam int unsigned DW = $clog2(DRAIN_TIMEOUT + 1);

    sched_state_t  state_q, state_d;
    logic [1:0]    rst_sync_q;
    logic          rst_n;
    logic          valid_q, valid_d;
    logic          swap_q, swap_d;
    logic [7:0]    frame_cnt_q;
    logic          overrun_q, overrun_set_c;
    pose_t         pose_q;
    logic [DW-1:0] drain_cnt_q;
    logic          fire_c, last_c, latch_c, timeout_c;
    logic [HW-1:0] hcount;

    // Asynchronous assert, synchronous release.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) rst_sync_q <= '0;
        else           rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign fire_c    = valid_q && ray_if.ray_ready_in;
    assign latch_c   = (state_q == LATCH);
    assign timeout_c = (state_q == DRAIN) && (drain_cnt_q == DW'(DRAIN_TIMEOUT - 1));

    ray_issue_counter #(
        .SCREEN_WIDTH (SCREEN_WIDTH),
        .HW           (HW)
    ) u_issue_counter (
        .pixel_clk_in (pixel_clk_in),
        .rst_n_in     (rst_n),
        .clear        (latch_c),
        .advance      (fire_c),
        .hcount       (hcount),
        .last_c       (last_c)
    );

    always_ff @(posedge pixel_clk_in or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable_in) state_d = LATCH;
            LATCH:   state_d = ISSUE;
            ISSUE:   if (fire_c && last_c) state_d = DRAIN;
            DRAIN: begin
                if (ray_last_pixel_in && video_last_pixel_in) state_d = SWAP;
                else if (ray_last_pixel_in || timeout_c)      state_d = WAIT_VS;
            end
            WAIT_VS: if (video_last_pixel_in) state_d = SWAP;
            SWAP:    state_d = enable_in ? LATCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state.
    always_comb begin
        valid_d       = (state_d == ISSUE);
        swap_d        = (state_d == SWAP);
        overrun_set_c = timeout_c && !ray_last_pixel_in;
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            swap_q      <= 1'b0;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
            pose_q      <= '0;
            drain_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            swap_q      <= swap_d;
            if (swap_d)        frame_cnt_q <= frame_cnt_q + 8'(1);
            if (overrun_set_c) overrun_q   <= 1'b1;
            if (latch_c)       pose_q      <= pose_in;
            drain_cnt_q <= (state_q == DRAIN) ? drain_cnt_q + DW'(1) : '0;
        end
    end

    assign ray_if.ray_valid_out = valid_q;
    assign ray_if.hcount_out    = hcount;
    assign ray_if.pose_out      = pose_q;
    assign swap_out             = swap_q;
    assign frame_count_out      = frame_cnt_q;
    assign overrun_out          = overrun_q;
    assign state_out            = state_q;

endmodule
